// File: rtl/ddc_edid_if.sv
// DDC pin and EDID storage bundle seen by the EDID responder.
interface ddc_edid_if;
  logic       scl_input;
  logic       sda_input;
  logic       sda_output;
  logic [7:0] edid_address;
  logic [7:0] edid_data;
  logic       active;
  logic       read_strobe;

  modport slave (
    input  scl_input, sda_input, edid_data,
    output sda_output, edid_address, active, read_strobe
  );
  modport master (
    output scl_input, sda_input, edid_data,
    input  sda_output, edid_address, active, read_strobe
  );
endinterface

// File: rtl/ddc_edid_responder.sv
// I2C/DDC target at DEVICE_ADDRESS serving a read-only 256-byte EDID image
// from external synchronous storage, with auto-incrementing word offset.
module ddc_pin_filter #(
  parameter int FILTER_LENGTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic level
);
  logic [1:0] sync;
  logic [3:0] cnt;

  // level follows the synchronized pin only after FILTER_LENGTH differing samples
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == level) cnt <= '0;
      else if (cnt == 4'(FILTER_LENGTH - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else cnt <= cnt + 4'd1;
    end
  end
endmodule

module ddc_edid_responder #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h50,
  parameter int         FILTER_LENGTH  = 4
) (
  input  logic     clock,
  input  logic     reset_n,
  ddc_edid_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, ADDRESS, ADDRESS_ACK, WRITE_OFFSET, OFFSET_ACK,
    WRITE_DATA, READ_DATA, READ_ACK, IGNORE
  } state_t;

  state_t     state, state_d;
  logic [7:0] shift, shift_d, offset, offset_d;
  logic [3:0] bit_cnt, bit_cnt_d;
  logic [1:0] ld_cnt, ld_cnt_d;
  logic       sda_r, sda_d, active_r, active_d, strobe_r, strobe_d;
  logic       rw, rw_d, acked, acked_d;
  logic [1:0] pins, filt;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, start_c, stop_c, load_win;

  assign pins = {bus.sda_input, bus.scl_input};

  ddc_pin_filter #(.FILTER_LENGTH(FILTER_LENGTH)) u_filt [1:0] (
    .clock(clock), .reset_n(reset_n), .pin(pins), .level(filt)
  );

  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
  // storage answers one clock after the offset moves; fetch on the second
  assign load_win = ~scl_f && ld_cnt != 2'd2 &&
                    ((state == ADDRESS_ACK && rw) || state == READ_ACK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shift    <= '0;
      offset   <= '0;
      bit_cnt  <= '0;
      ld_cnt   <= '0;
      sda_r    <= 1'b1;
      active_r <= 1'b0;
      strobe_r <= 1'b0;
      rw       <= 1'b0;
      acked    <= 1'b0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      offset   <= offset_d;
      bit_cnt  <= bit_cnt_d;
      ld_cnt   <= ld_cnt_d;
      sda_r    <= sda_d;
      active_r <= active_d;
      strobe_r <= strobe_d;
      rw       <= rw_d;
      acked    <= acked_d;
      scl_q    <= scl_f;
      sda_q    <= sda_f;
    end
  end

  always_comb begin
    state_d   = state;
    shift_d   = shift;
    offset_d  = offset;
    bit_cnt_d = bit_cnt;
    ld_cnt_d  = ld_cnt;
    sda_d     = sda_r;
    active_d  = active_r;
    strobe_d  = 1'b0;
    rw_d      = rw;
    acked_d   = acked;

    if (load_win) begin
      ld_cnt_d = ld_cnt + 2'd1;
      if (ld_cnt == 2'd1) begin
        shift_d  = bus.edid_data;
        strobe_d = 1'b1;
      end
    end

    case (state)
      IDLE: ;
      ADDRESS: begin
        if (scl_rise && bit_cnt != 4'd8) begin
          shift_d   = {shift[6:0], sda_f};
          bit_cnt_d = bit_cnt + 4'd1;
        end else if (scl_fall && bit_cnt == 4'd8) begin
          if (shift[7:1] == DEVICE_ADDRESS) begin
            state_d  = ADDRESS_ACK;
            sda_d    = 1'b0;
            active_d = 1'b1;
            rw_d     = shift[0];
            ld_cnt_d = '0;
          end else begin
            state_d  = IGNORE;
            active_d = 1'b0;
          end
        end
      end
      ADDRESS_ACK: begin
        if (scl_fall) begin
          bit_cnt_d = '0;
          if (rw) begin
            state_d = READ_DATA;
            sda_d   = shift[7];
          end else begin
            state_d = WRITE_OFFSET;
            sda_d   = 1'b1;
          end
        end
      end
      WRITE_OFFSET: begin
        if (scl_rise && bit_cnt != 4'd8) begin
          shift_d   = {shift[6:0], sda_f};
          bit_cnt_d = bit_cnt + 4'd1;
        end else if (scl_fall && bit_cnt == 4'd8) begin
          offset_d = shift;
          state_d  = OFFSET_ACK;
          sda_d    = 1'b0;
        end
      end
      OFFSET_ACK: begin
        if (scl_fall) begin
          state_d   = WRITE_DATA;
          sda_d     = 1'b1;
          bit_cnt_d = '0;
        end
      end
      WRITE_DATA: begin
        // storage is read-only: data bytes are never acknowledged
        if (scl_rise && bit_cnt != 4'd8) bit_cnt_d = bit_cnt + 4'd1;
        else if (scl_fall && bit_cnt == 4'd8) begin
          state_d  = IGNORE;
          active_d = 1'b0;
        end
      end
      READ_DATA: begin
        if (scl_fall) begin
          if (bit_cnt == 4'd7) begin
            state_d  = READ_ACK;
            sda_d    = 1'b1;
            offset_d = offset + 8'd1;
            ld_cnt_d = '0;
            acked_d  = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt + 4'd1;
            shift_d   = {shift[6:0], 1'b0};
            sda_d     = shift[6];
          end
        end
      end
      READ_ACK: begin
        if (scl_rise) begin
          if (sda_f) begin
            state_d  = IGNORE;
            active_d = 1'b0;
          end else acked_d = 1'b1;
        end else if (scl_fall && acked) begin
          state_d   = READ_DATA;
          sda_d     = shift[7];
          bit_cnt_d = '0;
        end
      end
      IGNORE: ;
      default: state_d = IDLE;
    endcase

    if (start_c) begin
      state_d   = ADDRESS;
      bit_cnt_d = '0;
      sda_d     = 1'b1;
    end else if (stop_c) begin
      state_d  = IDLE;
      sda_d    = 1'b1;
      active_d = 1'b0;
    end
  end

  assign bus.sda_output   = sda_r;
  assign bus.edid_address = offset;
  assign bus.active       = active_r;
  assign bus.read_strobe  = strobe_r;
endmodule

// File: tb/tb_ddc_edid_responder.sv
// Directed bench: bit-banged DDC master, open-drain SDA, ROM = addr ^ 0x5A.
module tb_ddc_edid_responder;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mon_err = 0;
  int   strobes = 0;
  logic mon_en = 1'b0;

  ddc_edid_if bus();

  assign bus.scl_input = m_scl;
  assign bus.sda_input = m_sda & bus.sda_output;

  always_ff @(posedge clock) bus.edid_data <= bus.edid_address ^ 8'h5A;

  ddc_edid_responder #(.DEVICE_ADDRESS(7'h50), .FILTER_LENGTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mon_en && bus.sda_output !== 1'b1) mon_err++;
    if (bus.read_strobe === 1'b1) strobes++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b, output logic r);
    tick(5); m_sda = b;
    tick(5); m_scl = 1'b1;
    tick(5); r = bus.sda_input;
    tick(5); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    tick(5);  m_sda = 1'b1;
    tick(5);  m_scl = 1'b1;
    tick(10); m_sda = 1'b0;
    tick(10); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(5);  m_sda = 1'b0;
    tick(5);  m_scl = 1'b1;
    tick(10); m_sda = 1'b1;
    tick(10);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, r);
      d = {d[6:0], r};
    end
    send_bit(nack, r);
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    logic [2:0] bits;
    int         base, sbase;

    // reset state
    tick(3);
    check("rst_sda", bus.sda_output, 1'b1);
    check("rst_addr", bus.edid_address, 8'h00);
    check("rst_active", bus.active, 1'b0);
    reset_n = 1'b1;
    base = mon_err; mon_en = 1'b1;
    tick(60);
    mon_en = 1'b0;
    check("idle_sda_quiet", mon_err - base, 0);
    check("idle_active", bus.active, 1'b0);

    // random read from offset 0x10
    sbase = strobes;
    i2c_start();
    write_byte(8'hA0, ack); check("rr_ack_a0", ack, 1'b0);
    write_byte(8'h10, ack); check("rr_ack_off", ack, 1'b0);
    i2c_start();
    write_byte(8'hA1, ack); check("rr_ack_a1", ack, 1'b0);
    check("rr_active", bus.active, 1'b1);
    read_byte(1'b0, d); check("rr_d0", d, 8'h4A);
    read_byte(1'b0, d); check("rr_d1", d, 8'h4B);
    read_byte(1'b1, d); check("rr_d2", d, 8'h48);
    i2c_stop();
    check("rr_addr", bus.edid_address, 8'h13);
    check("rr_active_end", bus.active, 1'b0);
    check("rr_strobes", strobes - sbase, 4);

    // wrong address
    base = mon_err; mon_en = 1'b1;
    i2c_start();
    write_byte(8'hA4, ack); check("wa_nack", ack, 1'b1);
    write_byte(8'h33, ack);
    write_byte(8'h44, ack);
    write_byte(8'h55, ack);
    i2c_stop();
    mon_en = 1'b0;
    check("wa_sda_quiet", mon_err - base, 0);
    check("wa_addr", bus.edid_address, 8'h13);
    check("wa_active", bus.active, 1'b0);

    // wraparound
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'hFF, ack); check("wr_ack_off", ack, 1'b0);
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(1'b0, d); check("wr_d0", d, 8'hA5);
    read_byte(1'b1, d); check("wr_d1", d, 8'h5A);
    i2c_stop();
    check("wr_addr", bus.edid_address, 8'h01);

    // 2-clock SDA glitch while SCL high: no START, address not acked
    tick(20); m_sda = 1'b0;
    tick(2);  m_sda = 1'b1;
    tick(20); m_scl = 1'b0;
    write_byte(8'hA1, ack);
    check("gl2_no_ack", ack, 1'b1);
    check("gl2_active", bus.active, 1'b0);
    i2c_stop();

    // 5-clock SDA low while SCL high is a START
    tick(20); m_sda = 1'b0;
    tick(5);  m_scl = 1'b0;
    write_byte(8'hA0, ack);
    check("gl5_ack", ack, 1'b0);
    check("gl5_active", bus.active, 1'b1);
    i2c_stop();
    check("gl5_active_end", bus.active, 1'b0);

    // STOP at bit 4 of a read byte (0x20 ^ 0x5A = 0x7A)
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1, r);
      bits[2-i] = r;
    end
    check("ab_bits", bits, 3'b011);
    tick(5);  m_sda = 1'b0;
    tick(5);  m_scl = 1'b1;
    tick(10); m_sda = 1'b1;
    tick(7);
    check("ab_sda_rel", bus.sda_output, 1'b1);
    check("ab_active", bus.active, 1'b0);
    base = mon_err; mon_en = 1'b1;
    m_scl = 1'b0; tick(10);
    for (int i = 0; i < 4; i++) send_bit(1'b1, r);
    mon_en = 1'b0;
    check("ab_idle_quiet", mon_err - base, 0);
    i2c_stop();

    // reset during ADDRESS_ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'hA0;
      send_bit(d[i], r);
    end
    tick(8);
    check("ra_ack_driven", bus.sda_output, 1'b0);
    reset_n = 1'b0;
    #1;
    check("ra_sda", bus.sda_output, 1'b1);
    check("ra_addr", bus.edid_address, 8'h00);
    check("ra_active", bus.active, 1'b0);
    tick(2);
    m_scl = 1'b1;
    m_sda = 1'b1;
    reset_n = 1'b1;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
